// File: rtl/decoder_scan_seq.sv
// Registered one-hot decoder with a handshake address port and an automatic scan sequencer.
// Build option: define DECODER_SCAN_ONESHOT_EN to end a scan in HOLD at the wrap to index 0.
module decoder_scan_seq #(
  parameter int AW = 3,
  parameter int DW = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                a_valid,
  input  logic [AW-1:0]       a,
  output logic                a_ready,
  input  logic                start,
  input  logic                stop,
  input  logic                clr,
  input  logic [DW-1:0]       dwell,
  output logic [(2**AW)-1:0]  y,
  output logic [AW-1:0]       y_idx,
  output logic                busy,
  output logic                wrap
);

  localparam int OW = 2 ** AW;
  localparam logic [AW-1:0] IDX_LAST = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    SCAN = 2'd2
  } state_t;

  state_t        state;
  logic [AW-1:0] idx;
  logic [DW-1:0] cnt;
  logic          y_act;
  logic          hs;

  // Address is refused while scanning and whenever a higher-priority request is present.
  assign a_ready = (state != SCAN) && !start && !clr;
  assign hs      = a_valid && a_ready;
  assign busy    = (state == SCAN);
  assign y_idx   = idx;
  assign y       = (en && y_act) ? (OW'(1) << idx) : '0;

  // NOTE: every register here uses <= so all next-state terms read the pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      cnt   <= '0;
      y_act <= 1'b0;
      wrap  <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (clr) begin
        state <= IDLE;
        y_act <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start) begin
              state <= SCAN;
              y_act <= 1'b1;
              cnt   <= dwell;
            end else if (hs) begin
              state <= HOLD;
              y_act <= 1'b1;
              idx   <= a;
            end
          end
          HOLD: begin
            if (start) begin
              state <= SCAN;
              cnt   <= dwell;
            end else if (hs) begin
              idx <= a;
            end
          end
          SCAN: begin
            if (stop) begin
              state <= HOLD;
            end else if (en) begin
              if (cnt == '0) begin
                idx <= idx + 1'b1;
                cnt <= dwell;
                if (idx == IDX_LAST) begin
                  wrap <= 1'b1;
`ifdef DECODER_SCAN_ONESHOT_EN
                  state <= HOLD;
`else
                  state <= SCAN;
`endif
                end
              end else begin
                cnt <= cnt - 1'b1;
              end
            end
          end
          default: begin
            state <= IDLE;
            y_act <= 1'b0;
          end
        endcase
      end
    end
  end

  a_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(y));
  a_busy_act: assert property (@(posedge clk) disable iff (rst) busy |-> y_act);

endmodule

// File: tb/tb_decoder_scan_seq.sv
// Scoreboard bench for decoder_scan_seq (AW=3): the driver queues expected outputs per cycle,
// a negedge monitor pops and compares them.
module tb_decoder_scan_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       a_valid;
  logic [2:0] a;
  logic       a_ready;
  logic       start;
  logic       stop;
  logic       clr;
  logic [3:0] dwell;
  logic [7:0] y;
  logic [2:0] y_idx;
  logic       busy;
  logic       wrap;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic [7:0] y;
    logic [2:0] idx;
    logic       busy;
    logic       wrap;
    logic       ready;
  } exp_t;

  exp_t sb[$];

`ifdef DECODER_SCAN_ONESHOT_EN
  localparam bit ONESHOT = 1'b1;
`else
  localparam bit ONESHOT = 1'b0;
`endif

  decoder_scan_seq #(.AW(3), .DW(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .a_valid (a_valid),
    .a       (a),
    .a_ready (a_ready),
    .start   (start),
    .stop    (stop),
    .clr     (clr),
    .dwell   (dwell),
    .y       (y),
    .y_idx   (y_idx),
    .busy    (busy),
    .wrap    (wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Monitor: outputs are compared mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check({e.name, ".y"},     32'(y),       32'(e.y));
      check({e.name, ".idx"},   32'(y_idx),   32'(e.idx));
      check({e.name, ".busy"},  32'(busy),    32'(e.busy));
      check({e.name, ".wrap"},  32'(wrap),    32'(e.wrap));
      check({e.name, ".ready"}, 32'(a_ready), 32'(e.ready));
    end
  end

  // Inputs for this cycle are already driven; queue what the outputs must show, then advance.
  task automatic cyc(input string nm, input logic [7:0] ey, input logic [2:0] ei,
                     input logic eb, input logic ew, input logic er);
    exp_t e;
    e.name = nm; e.y = ey; e.idx = ei; e.busy = eb; e.wrap = ew; e.ready = er;
    sb.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0; stop = 1'b0; clr = 1'b0; a_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; en = 1'b1; a_valid = 1'b0; a = '0;
    start = 1'b0; stop = 1'b0; clr = 1'b0; dwell = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    cyc("reset", 8'h00, 3'd0, 0, 0, 1);

    // Address load and output enable gating.
    a_valid = 1'b1; a = 3'd5;
    cyc("hs_idle", 8'h00, 3'd0, 0, 0, 1);
    cyc("load5", 8'h20, 3'd5, 0, 0, 1);
    en = 1'b0;
    cyc("en_off", 8'h00, 3'd5, 0, 0, 1);
    en = 1'b1;
    cyc("en_on", 8'h20, 3'd5, 0, 0, 1);
    a_valid = 1'b1; a = 3'd6;
    cyc("hs_hold", 8'h20, 3'd5, 0, 0, 1);

    // Scan from 6 with dwell=1: two cycles per position, wrap on first 0x01.
    start = 1'b1; dwell = 4'd1;
    cyc("start6", 8'h40, 3'd6, 0, 0, 0);
    cyc("scan6a", 8'h40, 3'd6, 1, 0, 0);
    cyc("scan6b", 8'h40, 3'd6, 1, 0, 0);
    cyc("scan7a", 8'h80, 3'd7, 1, 0, 0);
    cyc("scan7b", 8'h80, 3'd7, 1, 0, 0);
    stop = 1'b1;
    cyc("wrap0", 8'h01, 3'd0, !ONESHOT, 1, ONESHOT);
    cyc("held0", 8'h01, 3'd0, 0, 0, 1);

    // start and a_valid together: address refused, scan from old index, dwell=2.
    start = 1'b1; a_valid = 1'b1; a = 3'd2; dwell = 4'd2;
    cyc("start_hs", 8'h01, 3'd0, 0, 0, 0);
    for (int i = 0; i < 9; i++)
      cyc("scan_d2", 8'h01 << (i / 3), 3'(i / 3), 1, 0, 0);
    cyc("scan3_first", 8'h08, 3'd3, 1, 0, 0);

    // Pause at idx 3 with one count left, then resume.
    en = 1'b0;
    for (int i = 0; i < 5; i++)
      cyc("paused", 8'h00, 3'd3, 1, 0, 0);
    en = 1'b1;
    cyc("resume_a", 8'h08, 3'd3, 1, 0, 0);
    cyc("resume_b", 8'h08, 3'd3, 1, 0, 0);
    stop = 1'b1;
    cyc("step4_stop", 8'h10, 3'd4, 1, 0, 0);
    cyc("stopped_a", 8'h10, 3'd4, 0, 0, 1);
    cyc("stopped_b", 8'h10, 3'd4, 0, 0, 1);

    // clr beats stop in SCAN; index retained, output off.
    start = 1'b1; dwell = 4'd0;
    cyc("start4", 8'h10, 3'd4, 0, 0, 0);
    cyc("scan4", 8'h10, 3'd4, 1, 0, 0);
    clr = 1'b1; stop = 1'b1;
    cyc("clr_stop", 8'h20, 3'd5, 1, 0, 0);
    cyc("idle_after_clr", 8'h00, 3'd5, 0, 0, 1);

    // Async reset mid-scan.
    start = 1'b1;
    cyc("start_idle", 8'h00, 3'd5, 0, 0, 0);
    cyc("scan5", 8'h20, 3'd5, 1, 0, 0);
    cyc("scan6", 8'h40, 3'd6, 1, 0, 0);
    rst = 1'b1;
    begin
      exp_t e;
      e.name = "async_rst"; e.y = 8'h00; e.idx = 3'd0; e.busy = 1'b0; e.wrap = 1'b0; e.ready = 1'b1;
      sb.push_back(e);
    end
    @(negedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // Dwell 0 across the wrap: one-shot build returns to HOLD at index 0.
    a_valid = 1'b1; a = 3'd6;
    cyc("hs6", 8'h00, 3'd0, 0, 0, 1);
    start = 1'b1; dwell = 4'd0;
    cyc("start6_d0", 8'h40, 3'd6, 0, 0, 0);
    cyc("d0_6", 8'h40, 3'd6, 1, 0, 0);
    cyc("d0_7", 8'h80, 3'd7, 1, 0, 0);
    cyc("d0_wrap", 8'h01, 3'd0, !ONESHOT, 1, ONESHOT);
    stop = 1'b1;
    cyc("d0_after", ONESHOT ? 8'h01 : 8'h02, ONESHOT ? 3'd0 : 3'd1, !ONESHOT, 0, ONESHOT);
    cyc("d0_hold", ONESHOT ? 8'h01 : 8'h02, ONESHOT ? 3'd0 : 3'd1, 0, 0, 1);

    @(negedge clk);
    #1;
    check("queue_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
